// File: rtl/cnn_seq_ctrl.sv
// cnn_seq_ctrl: OBI-mapped sequencer for the CNN conv -> ReLU datapath.
// Software programs IN_BASE, OUT_BASE and NUM_PIX, then writes CTRL.START.
// The block issues one input-pixel address per pixel handshake and gives one
// output address to each ReLU result it accepts. It raises DONE (and irq_o if
// enabled) once NUM_PIX results have been accepted.
//
// Ports:
//   clk_i, rst_ni           clock, synchronous active-low reset
//   obi_req_i/obi_gnt_o     OBI request / grant (grant always equals request)
//   obi_addr_i, obi_we_i    OBI byte address, write enable
//   obi_wdata_i             OBI write data
//   obi_rvalid_o            response valid, one cycle after every request
//   obi_rdata_o, obi_err_o  registered response data / unmapped-offset error
//   pix_valid_o/pix_ready_i input-pixel address handshake, pix_addr_o = address
//   res_valid_i/res_ready_o ReLU result handshake, res_addr_o = output address
//   done_o, irq_o           sticky completion flag, completion interrupt
module cnn_seq_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       CNT_W    = 16,
  parameter logic [ADDR_W-1:0] REG_BASE = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              obi_req_i,
  output logic              obi_gnt_o,
  input  logic [ADDR_W-1:0] obi_addr_i,
  input  logic              obi_we_i,
  input  logic [31:0]       obi_wdata_i,
  output logic              obi_rvalid_o,
  output logic [31:0]       obi_rdata_o,
  output logic              obi_err_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic [31:0]       pix_addr_o,
  input  logic              res_valid_i,
  output logic              res_ready_o,
  output logic [31:0]       res_addr_o,
  output logic              done_o,
  output logic              irq_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [2:0] IdxCtrl    = 3'd0;
  localparam logic [2:0] IdxStatus  = 3'd1;
  localparam logic [2:0] IdxInBase  = 3'd2;
  localparam logic [2:0] IdxOutBase = 3'd3;
  localparam logic [2:0] IdxNumPix  = 3'd4;
  localparam logic [2:0] IdxPixCnt  = 3'd5;
  localparam logic [2:0] IdxResCnt  = 3'd6;

  // State
  state_e             r_state;
  logic               r_irq_en;
  logic               r_done;
  logic [31:0]        r_in_base;
  logic [31:0]        r_out_base;
  logic [CNT_W-1:0]   r_num_pix;
  logic [CNT_W-1:0]   r_pix_cnt;
  logic [CNT_W-1:0]   r_res_cnt;
  logic               r_rvalid;
  logic [31:0]        r_rdata;
  logic               r_err;

  // Decode
  logic [ADDR_W-1:0]  w_offset;
  logic [2:0]         w_idx;
  logic               w_oob;
  logic               w_wr;
  logic               w_rd;
  logic               w_wr_ctrl;
  logic               w_cfg_we;
  logic               w_start;
  logic               w_abort;
  logic               w_w1c;
  logic               w_busy;
  logic [31:0]        w_rdata;

  // Datapath handshakes and next state
  logic               w_pix_fire;
  logic               w_res_fire;
  logic               w_res_last;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   w_pix_cnt_nxt;
  logic [CNT_W-1:0]   w_res_cnt_nxt;
  logic               w_done_nxt;

  assign w_offset  = obi_addr_i - REG_BASE;
  assign w_idx     = w_offset[4:2];
  // Whole offset takes part in the range check, so aliases above 0x1C error.
  assign w_oob     = (w_offset >= ADDR_W'(28));
  assign w_wr      = obi_req_i & obi_we_i & ~w_oob;
  assign w_rd      = obi_req_i & ~obi_we_i & ~w_oob;
  assign w_wr_ctrl = w_wr & (w_idx == IdxCtrl);
  assign w_start   = w_wr_ctrl & obi_wdata_i[0];
  assign w_abort   = w_wr_ctrl & obi_wdata_i[1];
  assign w_w1c     = w_wr & (w_idx == IdxStatus) & obi_wdata_i[1];
  assign w_busy    = (r_state == StRun);
  // Job configuration is frozen while a job runs; such writes are dropped.
  assign w_cfg_we  = ~w_busy;

  assign w_pix_fire = pix_valid_o & pix_ready_i;
  assign w_res_fire = res_valid_i & res_ready_o;
  assign w_res_last = ((r_res_cnt + CNT_W'(1)) == r_num_pix);

  assign obi_gnt_o    = obi_req_i;
  assign obi_rvalid_o = r_rvalid;
  assign obi_rdata_o  = r_rdata;
  assign obi_err_o    = r_err;

  assign pix_valid_o = w_busy & (r_pix_cnt < r_num_pix);
  assign res_ready_o = w_busy;
  assign pix_addr_o  = r_in_base + (32'(r_pix_cnt) << 2);
  assign res_addr_o  = r_out_base + (32'(r_res_cnt) << 2);
  assign done_o      = r_done;
  assign irq_o       = r_done & r_irq_en;

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_idx)
        IdxCtrl:    w_rdata = {29'd0, r_irq_en, 2'b00};
        IdxStatus:  w_rdata = {30'd0, r_done, w_busy};
        IdxInBase:  w_rdata = r_in_base;
        IdxOutBase: w_rdata = r_out_base;
        IdxNumPix:  w_rdata = 32'(r_num_pix);
        IdxPixCnt:  w_rdata = 32'(r_pix_cnt);
        IdxResCnt:  w_rdata = 32'(r_res_cnt);
        default:    w_rdata = '0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pix_cnt_nxt = r_pix_cnt;
    w_res_cnt_nxt = r_res_cnt;
    w_done_nxt    = r_done;
    // W1C first so that START or job completion below take precedence.
    if (w_w1c) begin
      w_done_nxt = 1'b0;
    end
    case (r_state)
      StIdle: begin
        if (w_start) begin
          w_pix_cnt_nxt = '0;
          w_res_cnt_nxt = '0;
          if (r_num_pix != '0) begin
            w_state_nxt = StRun;
            w_done_nxt  = 1'b0;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      StRun: begin
        if (w_pix_fire) begin
          w_pix_cnt_nxt = r_pix_cnt + CNT_W'(1);
        end
        if (w_res_fire) begin
          w_res_cnt_nxt = r_res_cnt + CNT_W'(1);
        end
        // Abort beats a completing result: leave without DONE.
        if (w_abort) begin
          w_state_nxt = StIdle;
        end else if (w_res_fire && w_res_last) begin
          w_state_nxt = StIdle;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_irq_en   <= 1'b0;
      r_done     <= 1'b0;
      r_in_base  <= '0;
      r_out_base <= '0;
      r_num_pix  <= '0;
      r_pix_cnt  <= '0;
      r_res_cnt  <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pix_cnt <= w_pix_cnt_nxt;
      r_res_cnt <= w_res_cnt_nxt;
      r_done    <= w_done_nxt;
      r_rvalid  <= obi_req_i;
      r_rdata   <= w_rdata;
      r_err     <= obi_req_i & w_oob;
      if (w_wr_ctrl) begin
        r_irq_en <= obi_wdata_i[2];
      end
      if (w_wr && w_cfg_we && (w_idx == IdxInBase)) begin
        r_in_base <= obi_wdata_i;
      end
      if (w_wr && w_cfg_we && (w_idx == IdxOutBase)) begin
        r_out_base <= obi_wdata_i;
      end
      if (w_wr && w_cfg_we && (w_idx == IdxNumPix)) begin
        r_num_pix <= obi_wdata_i[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// tb_cnn_seq_ctrl: bench for cnn_seq_ctrl. An emulated datapath accepts pixel
// addresses and returns one result per pixel after a programmable latency; the
// expected address streams are rebuilt from base + 4*index.
module tb_cnn_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic        pix_valid_o;
  logic        pix_ready_i = 1'b0;
  logic [31:0] pix_addr_o;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [31:0] res_addr_o;
  logic        done_o;
  logic        irq_o;

  always #5 clk_i = ~clk_i;

  cnn_seq_ctrl #(
    .ADDR_W   (32),
    .CNT_W    (16),
    .REG_BASE (32'h0)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o),
    .pix_valid_o  (pix_valid_o),
    .pix_ready_i  (pix_ready_i),
    .pix_addr_o   (pix_addr_o),
    .res_valid_i  (res_valid_i),
    .res_ready_o  (res_ready_o),
    .res_addr_o   (res_addr_o),
    .done_o       (done_o),
    .irq_o        (irq_o)
  );

  int checks = 0;
  int errors = 0;

  // Controls written only by the main sequence
  bit dp_en = 0, rnd_mode = 0, stall_chk_en = 0, res_manual = 0, man_res_valid = 0;
  int pix_limit = 1 << 20, res_limit = 1 << 20, lat = 3, exp_n = 0;
  int pix_base = 0, res_base = 0, flush_req = 0;
  bit m_irq_en = 0;
  logic [31:0] j_ib, j_ob;

  // State owned by the datapath emulator
  logic        auto_res_valid = 1'b0;
  int          cyc = 0, flush_seen = 0, stall_viol = 0, extra_pv = 0, done_seen = 0;
  logic        done_after_last = 1'b0, done_pend = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  int          pend_due[$];
  logic [31:0] pix_rec[$];
  logic [31:0] res_rec[$];

  assign res_valid_i = res_manual ? man_res_valid : auto_res_valid;

  // Datapath emulator: drive after posedge, observe on negedge.
  always begin
    @(posedge clk_i);
    #1;
    cyc++;
    if (flush_req != flush_seen) begin
      pend_due.delete();
      flush_seen = flush_req;
    end
    pix_ready_i = dp_en && ((pix_rec.size() - pix_base) < pix_limit) &&
                  (!rnd_mode || ($urandom_range(0, 1) == 1));
    auto_res_valid = dp_en && (pend_due.size() > 0) && (pend_due[0] <= cyc) &&
                     ((res_rec.size() - res_base) < res_limit) &&
                     (!rnd_mode || ($urandom_range(0, 2) != 0));
    @(negedge clk_i);
    if (done_pend) begin
      done_after_last = done_o;
      done_seen++;
      done_pend = 1'b0;
    end
    if (stall_chk_en && prev_stall && (!pix_valid_o || (pix_addr_o !== prev_addr))) begin
      stall_viol++;
    end
    prev_stall = pix_valid_o && !pix_ready_i;
    prev_addr  = pix_addr_o;
    if (pix_valid_o && ((pix_rec.size() - pix_base) >= exp_n)) extra_pv++;
    if (pix_valid_o && pix_ready_i) begin
      pix_rec.push_back(pix_addr_o);
      pend_due.push_back(cyc + lat);
    end
    if (res_valid_i && res_ready_o) begin
      res_rec.push_back(res_addr_o);
      if (pend_due.size() > 0) void'(pend_due.pop_front());
      if ((res_rec.size() - res_base) == exp_n) done_pend = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic obi(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    @(posedge clk_i);
    #1;
    obi_req_i   = 1'b1;
    obi_we_i    = we;
    obi_addr_i  = addr;
    obi_wdata_i = wdata;
    @(negedge clk_i);
    chk("gnt", obi_gnt_o, 1);
    @(posedge clk_i);
    #1;
    obi_req_i = 1'b0;
    obi_we_i  = 1'b0;
    @(negedge clk_i);
    chk("rvalid", obi_rvalid_o, 1);
    rdata = obi_rdata_o;
    err   = obi_err_o;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rdat;
    logic        e;
    obi(1'b1, a, d, rdat, e);
    chk("wr_rdata", rdat, 0);
    chk("wr_err", e, (a >= 32'h1C) ? 1 : 0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] rdat;
    logic        e;
    obi(1'b0, a, 32'h0, rdat, e);
    chk(tag, rdat, exp);
    chk({tag, "_err"}, e, 0);
  endtask

  task automatic run_job(input logic [31:0] ib, input logic [31:0] ob, input int n,
                         input bit rnd);
    int sv0, ep0, ds0;
    pix_base = pix_rec.size();
    res_base = res_rec.size();
    exp_n    = n;
    rnd_mode = rnd;
    sv0 = stall_viol;
    ep0 = extra_pv;
    ds0 = done_seen;
    stall_chk_en = 1;
    wr(32'h08, ib);
    wr(32'h0C, ob);
    wr(32'h10, n);
    dp_en = 1;
    wr(32'h00, {29'd0, m_irq_en, 2'b01});
    chk("done_clr_on_start", done_o, 0);
    for (int t = 0; t < 3000 && (res_rec.size() - res_base) < n; t++) @(negedge clk_i);
    chk("job_res_count", res_rec.size() - res_base, n);
    repeat (2) @(negedge clk_i);
    dp_en = 0;
    stall_chk_en = 0;
    chk("done_after_last", done_after_last, 1);
    chk("done_seen_once", done_seen - ds0, 1);
    chk("done_end", done_o, 1);
    chk("irq_end", irq_o, m_irq_en);
    rd(32'h04, 32'h2, "status_end");
    rd(32'h14, n, "pix_cnt_end");
    rd(32'h18, n, "res_cnt_end");
    rd(32'h00, {29'd0, m_irq_en, 2'b00}, "ctrl_end");
    chk("pix_count", pix_rec.size() - pix_base, n);
    chk("extra_pix_valid", extra_pv - ep0, 0);
    chk("stall_stable", stall_viol - sv0, 0);
    for (int i = 0; i < n; i++) begin
      if (pix_base + i < pix_rec.size())
        chk($sformatf("pix_addr[%0d]", i), pix_rec[pix_base + i], ib + 32'(4 * i));
      if (res_base + i < res_rec.size())
        chk($sformatf("res_addr[%0d]", i), res_rec[res_base + i], ob + 32'(4 * i));
    end
  endtask

  initial begin
    int ep0, ds0;
    logic [31:0] rdat;
    logic        e;
    rst_ni = 1'b0;
    obi_req_i = 1'b0;
    obi_we_i = 1'b0;
    obi_addr_i = '0;
    obi_wdata_i = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_rvalid", obi_rvalid_o, 0);
    chk("rst_rdata", obi_rdata_o, 0);
    chk("rst_err", obi_err_o, 0);
    chk("rst_pix_valid", pix_valid_o, 0);
    chk("rst_res_ready", res_ready_o, 0);
    chk("rst_pix_addr", pix_addr_o, 0);
    chk("rst_res_addr", res_addr_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_gnt_low", obi_gnt_o, 0);
    obi_req_i = 1'b1;
    #1;
    chk("rst_gnt_follows_req", obi_gnt_o, 1);
    obi_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Register window reads after reset, response lasts one cycle
    for (int a = 0; a < 7; a++) begin
      rd(32'(4 * a), 0, $sformatf("reset_reg_%0d", a));
      @(negedge clk_i);
      chk("rvalid_one_cycle", obi_rvalid_o, 0);
    end
    obi(1'b0, 32'h1C, 32'h0, rdat, e);
    chk("oob_rd_err", e, 1);
    chk("oob_rd_rdata", rdat, 0);
    wr(32'h1C, 32'hFFFF_FFFF);
    wr(32'h40, 32'h0000_0007);
    rd(32'h00, 0, "ctrl_after_oob_wr");

    // Directed jobs
    m_irq_en = 0;
    lat = 3;
    run_job(32'h1000, 32'h2000, 4, 0);
    run_job(32'h1000, 32'h2000, 4, 1);

    // Zero-length job
    wr(32'h04, 32'h2);
    chk("done_w1c", done_o, 0);
    pix_base = pix_rec.size();
    exp_n = 0;
    ep0 = extra_pv;
    dp_en = 1;
    wr(32'h10, 0);
    wr(32'h00, 32'h1);
    chk("zero_done_next", done_o, 1);
    repeat (4) @(negedge clk_i);
    dp_en = 0;
    chk("zero_no_pix", pix_rec.size() - pix_base, 0);
    chk("zero_no_valid", extra_pv - ep0, 0);
    rd(32'h04, 32'h2, "zero_status");
    wr(32'h04, 32'h2);
    chk("zero_w1c_done", done_o, 0);
    rd(32'h04, 32'h0, "zero_status_clr");

    // Abort after three pixels; config frozen while busy
    pix_base = pix_rec.size();
    res_base = res_rec.size();
    exp_n = 8;
    pix_limit = 3;
    res_limit = 0;
    rnd_mode = 0;
    wr(32'h10, 8);
    dp_en = 1;
    wr(32'h00, 32'h1);
    for (int t = 0; t < 200 && (pix_rec.size() - pix_base) < 3; t++) @(negedge clk_i);
    chk("abort_pix_seen", pix_rec.size() - pix_base, 3);
    wr(32'h10, 2);
    rd(32'h10, 8, "num_pix_locked");
    wr(32'h08, 32'hDEAD_0000);
    rd(32'h08, 32'h1000, "in_base_locked");
    rd(32'h04, 32'h1, "status_busy");
    wr(32'h00, 32'h2);
    chk("abort_pix_valid", pix_valid_o, 0);
    chk("abort_res_ready", res_ready_o, 0);
    rd(32'h04, 32'h0, "status_after_abort");
    rd(32'h14, 3, "abort_pix_cnt");
    rd(32'h18, 0, "abort_res_cnt");
    chk("abort_no_done", done_o, 0);
    dp_en = 0;
    flush_req++;
    pix_limit = 1 << 20;
    res_limit = 1 << 20;
    wr(32'h00, 32'h2);
    rd(32'h04, 32'h0, "abort_idle_noop");
    rd(32'h14, 3, "abort_cnt_hold");

    // IRQ, and DONE W1C colliding with the final result
    m_irq_en = 1;
    wr(32'h00, 32'h4);
    rd(32'h00, 32'h4, "ctrl_irq_en");
    pix_base = pix_rec.size();
    res_base = res_rec.size();
    exp_n = 4;
    res_limit = 3;
    ds0 = done_seen;
    wr(32'h08, 32'h3000);
    wr(32'h0C, 32'h4000);
    wr(32'h10, 4);
    dp_en = 1;
    wr(32'h00, 32'h5);
    chk("irq_clr_on_start", irq_o, 0);
    for (int t = 0; t < 500 && !(((res_rec.size() - res_base) == 3) &&
                                ((pix_rec.size() - pix_base) == 4)); t++)
      @(negedge clk_i);
    repeat (5) @(negedge clk_i);
    chk("irq_before_last", irq_o, 0);
    @(posedge clk_i);
    #1;
    res_manual = 1;
    man_res_valid = 1;
    obi_req_i = 1'b1;
    obi_we_i = 1'b1;
    obi_addr_i = 32'h04;
    obi_wdata_i = 32'h2;
    @(negedge clk_i);
    chk("last_res_ready", res_ready_o, 1);
    chk("last_res_addr", res_addr_o, 32'h400C);
    @(posedge clk_i);
    #1;
    man_res_valid = 0;
    res_manual = 0;
    obi_req_i = 1'b0;
    obi_we_i = 1'b0;
    @(negedge clk_i);
    chk("w1c_rvalid", obi_rvalid_o, 1);
    chk("done_beats_w1c", done_o, 1);
    chk("irq_set", irq_o, 1);
    dp_en = 0;
    res_limit = 1 << 20;
    rd(32'h04, 32'h2, "status_after_collide");
    rd(32'h18, 4, "res_cnt_collide");
    chk("collide_done_seen", done_seen - ds0, 1);
    wr(32'h00, 32'h0);
    m_irq_en = 0;
    chk("irq_masked", irq_o, 0);
    chk("done_kept", done_o, 1);

    // Results offered while idle are refused
    res_manual = 1;
    man_res_valid = 1;
    repeat (3) begin
      @(negedge clk_i);
      chk("idle_res_ready", res_ready_o, 0);
    end
    man_res_valid = 0;
    res_manual = 0;
    rd(32'h18, 4, "res_cnt_idle");

    // Randomized jobs, including address wrap
    for (int k = 0; k < 4; k++) begin
      j_ib = (k == 0) ? 32'hFFFF_FFF4 : $urandom;
      j_ob = (k == 1) ? 32'hFFFF_FFF8 : $urandom;
      lat = $urandom_range(1, 5);
      m_irq_en = ($urandom_range(0, 1) == 1);
      run_job(j_ib, j_ob, $urandom_range(1, 10), 1);
    end

    // Reset in the middle of a job
    pix_base = pix_rec.size();
    res_base = res_rec.size();
    exp_n = 6;
    rnd_mode = 0;
    lat = 3;
    wr(32'h10, 6);
    dp_en = 1;
    wr(32'h00, 32'h5);
    repeat (2) @(negedge clk_i);
    dp_en = 0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    flush_req++;
    @(negedge clk_i);
    chk("midrst_pix_valid", pix_valid_o, 0);
    chk("midrst_res_ready", res_ready_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_irq", irq_o, 0);
    repeat (5) @(negedge clk_i);
    chk("midrst_done_later", done_o, 0);
    rd(32'h04, 0, "midrst_status");
    rd(32'h10, 0, "midrst_num_pix");
    rd(32'h14, 0, "midrst_pix_cnt");
    rd(32'h00, 0, "midrst_ctrl");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
